// File: rtl/zeta_pkg.sv
// Shared defaults and types for the zeta ROM address sequencer.
// The build may define NTT_STAGE_CNT to change the default stage count.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

package zeta_pkg;

  localparam int STAGE_CNT_DEF = `NTT_STAGE_CNT;
  localparam int N_DEF         = 1 << STAGE_CNT_DEF;
  localparam int B_DEF         = N_DEF / 4;
  localparam int ADDR_W_DEF    = STAGE_CNT_DEF - 1;

  typedef struct packed {
    logic vld;
    logic inv;
  } token_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/zeta_stage_cnt.sv
// One butterfly stage: beat counter, run/idle FSM and the two lane zeta addresses.
//   state   | meaning
//   ST_IDLE | no polynomial in this stage, outputs forced to 0
//   ST_RUN  | issuing beat cnt_q of the current polynomial
module zeta_stage_cnt
  import zeta_pkg::*;
#(
  parameter int STAGE_CNT = STAGE_CNT_DEF,
  parameter int STAGE_IDX = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  token_t                     tok,
  output logic                       vld,
  output logic                       inv,
  output logic                       last_beat,
  output logic [1:0][STAGE_CNT-2:0]  addr
);

  localparam int              AW    = STAGE_CNT - 1;
  localparam int              CW    = STAGE_CNT - 2;
  localparam int              SHIFT = STAGE_CNT - 1 - STAGE_IDX;
  localparam logic [CW-1:0]   LAST  = CW'((1 << CW) - 1);
  localparam logic [AW-1:0]   MASK  = AW'((1 << STAGE_IDX) - 1);

  stage_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic [1:0][AW-1:0] fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  // A token arriving on the last beat restarts the stage with no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    if (!stall) begin
      if (tok.vld) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        inv_d   = tok.inv;
      end else if (state_q == ST_RUN) begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          inv_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign vld       = (state_q == ST_RUN);
  assign inv       = vld & inv_q;
  assign last_beat = vld & (cnt_q == LAST);

  // Butterfly index j = {cnt, lane}; the inverse address mirrors it inside the 2^s-entry ROM.
  assign fwd[0] = {cnt_q, 1'b0} >> SHIFT;
  assign fwd[1] = {cnt_q, 1'b1} >> SHIFT;

  always_comb begin
    addr = '0;
    for (int l = 0; l < 2; l++) begin
      if (vld) begin
        addr[l] = inv_q ? (fwd[l] ^ MASK) : fwd[l];
      end
    end
  end

endmodule

// File: rtl/zeta_addr_seq.sv
// Twiddle ROM address sequencer: start handshake, per-stage token delay chains, done/busy.
// Optional ZETA_ADDR_STALL_EN adds a stall input that freezes the whole sequencer.
module zeta_addr_seq
  import zeta_pkg::*;
#(
  parameter int STAGE_CNT = STAGE_CNT_DEF,
  parameter int STAGE_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
`ifdef ZETA_ADDR_STALL_EN
  input  logic                                  stall,
`endif
  input  logic                                  start,
  output logic                                  start_ready,
  input  logic                                  inverse,
  output logic [1:0][STAGE_CNT-1:0][STAGE_CNT-2:0] rom_addr,
  output logic [STAGE_CNT-1:0]                  stage_vld,
  output logic [STAGE_CNT-1:0]                  stage_inv,
  output logic                                  done,
  output logic                                  busy
);

`ifndef ZETA_ADDR_STALL_EN
  logic stall;
  assign stall = 1'b0;
`endif

  token_t                    tok [STAGE_CNT];
  token_t                    dly [STAGE_CNT-1][STAGE_LAT];
  logic [STAGE_CNT-1:0]      last_beat;
  logic [1:0][STAGE_CNT-2:0] stage_addr [STAGE_CNT];
  logic                      accept;
  logic                      in_flight;

  assign start_ready = ~stall & (~stage_vld[0] | last_beat[0]);
  assign accept      = start & start_ready;

  // tok[s] is the token reaching stage s this cycle; stage s+1 sees it STAGE_LAT cycles later.
  always_comb begin
    tok[0] = '{vld: accept, inv: accept & inverse};
    for (int s = 1; s < STAGE_CNT; s++) begin
      tok[s] = dly[s-1][STAGE_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGE_CNT-1; s++) begin
        for (int k = 0; k < STAGE_LAT; k++) begin
          dly[s][k] <= '0;
        end
      end
    end else if (!stall) begin
      for (int s = 0; s < STAGE_CNT-1; s++) begin
        dly[s][0] <= tok[s];
        for (int k = 1; k < STAGE_LAT; k++) begin
          dly[s][k] <= dly[s][k-1];
        end
      end
    end
  end

  always_comb begin
    in_flight = 1'b0;
    for (int s = 0; s < STAGE_CNT-1; s++) begin
      for (int k = 0; k < STAGE_LAT; k++) begin
        in_flight = in_flight | dly[s][k].vld;
      end
    end
  end

  for (genvar s = 0; s < STAGE_CNT; s++) begin : g_stage
    zeta_stage_cnt #(
      .STAGE_CNT (STAGE_CNT),
      .STAGE_IDX (s)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .tok       (tok[s]),
      .vld       (stage_vld[s]),
      .inv       (stage_inv[s]),
      .last_beat (last_beat[s]),
      .addr      (stage_addr[s])
    );

    assign rom_addr[0][s] = stage_addr[s][0];
    assign rom_addr[1][s] = stage_addr[s][1];

    // Equal stage durations mean a token only ever lands on an idle or finishing stage.
    a_no_collision : assert property (@(posedge clk) disable iff (!rst_n)
      tok[s].vld |-> (!stage_vld[s] || last_beat[s]));
  end

  assign done = last_beat[STAGE_CNT-1] & ~stall;
  assign busy = (|stage_vld) | in_flight | accept;

endmodule
